// File: rtl/accumulator_drain_unit_if.sv
// ---------------------------------------------------------------------------
// accumulator_drain_unit_if
// Output row stream from the accumulator drain unit to the unified-buffer
// writer. A row transfers on out_valid & out_ready.
//   out_valid  master->slave  row valid
//   out_ready  slave->master  consumer ready
//   out_data   master->slave  packed int8 row, lane k at [8k+7:8k]
//   out_addr   master->slave  row index of out_data
// ---------------------------------------------------------------------------
interface accumulator_drain_unit_if #(
  parameter int MUL_SIZE   = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                          out_valid;
  logic                          out_ready;
  logic [MUL_SIZE*OUT_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0]         out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/accumulator_drain_unit.sv
// ---------------------------------------------------------------------------
// accumulator_drain_unit
// Drains accumulator rows in address order after a start pulse, requantises
// every 32-bit lane to int8 (arithmetic shift, optional ReLU, saturation) and
// streams packed rows to the unified-buffer writer through a 2-entry
// first-word-fall-through FIFO whose head is the registered output.
//
// Ports:
//   clk_i                  clock
//   rst_i                  asynchronous active-low reset
//   start_i                drain request, sampled only in IDLE
//   num_rows_i             rows to drain (0..1024), captured on start
//   shift_i                right-shift amount, captured on start
//   relu_en_i              clamp negatives to zero, captured on start
//   read_accumulator_o     accumulator read strobe
//   accumulator_addr_rd_o  accumulator read row address
//   accumulator_data_i     row data, valid the cycle after the strobe
//   out_if                 output row stream (master modport)
//   busy_o                 high from accepted start until done_o
//   done_o                 one-cycle pulse after the last output handshake
//
// Compile-time option:
//   ACCUM_DRAIN_ROUND_EN   when defined, adds 1<<(shift-1) before the shift
//                          (round half up); otherwise truncating shift.
// ---------------------------------------------------------------------------
module accumulator_drain_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH:0]           num_rows_i,
  input  logic [4:0]                    shift_i,
  input  logic                          relu_en_i,
  output logic                          read_accumulator_o,
  output logic [ADDR_WIDTH-1:0]         accumulator_addr_rd_o,
  input  logic [MUL_SIZE*ACC_WIDTH-1:0] accumulator_data_i,
  accumulator_drain_unit_if.master      out_if,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int ROW_W = MUL_SIZE * OUT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  // Lane requantisation. Work at ACC_WIDTH+1 bits so the rounding bias
  // cannot wrap a large positive accumulator into a negative one.
  function automatic logic signed [OUT_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic        [4:0]           sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] v;
`ifdef ACCUM_DRAIN_ROUND_EN
    logic signed [ACC_WIDTH:0] bias;
    bias = (sh == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (sh - 5'd1));
    ext  = {acc[ACC_WIDTH-1], acc} + bias;
`else
    ext  = {acc[ACC_WIDTH-1], acc};
`endif
    v = ext >>> sh;
    if (relu && (v < 0)) v = '0;
    if (v > SAT_MAX) v = SAT_MAX;
    if (v < SAT_MIN) v = SAT_MIN;
    return v[OUT_WIDTH-1:0];
  endfunction

  state_t                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH:0]     num_rows_q;
  logic [ADDR_WIDTH:0]     issued_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic                    inflight_q;
  logic [ADDR_WIDTH-1:0]   inflight_addr_q;

  logic                    head_v_q;
  logic [ROW_W-1:0]        head_data_q;
  logic [ADDR_WIDTH-1:0]   head_addr_q;
  logic                    tail_v_q;
  logic [ROW_W-1:0]        tail_data_q;
  logic [ADDR_WIDTH-1:0]   tail_addr_q;

  logic                    pop;
  logic                    push;
  logic [2:0]              used;
  logic [2:0]              cnt_d;
  logic                    rd_en;
  logic [ROW_W-1:0]        rq_row;

  // A popping head frees its slot in the same cycle, which is what lets the
  // 2-entry FIFO sustain one row per cycle across the read latency.
  assign pop   = head_v_q & out_if.out_ready;
  assign push  = inflight_q;
  assign used  = 3'(head_v_q) + 3'(tail_v_q) + 3'(inflight_q) - 3'(pop);
  assign cnt_d = 3'(head_v_q) + 3'(tail_v_q) + 3'(push) - 3'(pop);
  assign rd_en = (state_q == DRAIN) && (used < 3'd2);

  always_comb begin
    rq_row = '0;
    for (int k = 0; k < MUL_SIZE; k++) begin
      rq_row[k*OUT_WIDTH +: OUT_WIDTH] =
        requant(accumulator_data_i[k*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q);
    end
  end

  // Control FSM, read issue and in-flight tracking
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      num_rows_q      <= '0;
      issued_q        <= '0;
      addr_q          <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_addr_q <= addr_q;
        addr_q          <= addr_q + 1'b1;
        issued_q        <= issued_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            num_rows_q <= num_rows_i;
            shift_q    <= shift_i;
            relu_q     <= relu_en_i;
            addr_q     <= '0;
            issued_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= (num_rows_i == '0) ? FLUSH : DRAIN;
          end
        end
        DRAIN: begin
          if (rd_en && ((issued_q + 1'b1) == num_rows_q)) state_q <= FLUSH;
        end
        FLUSH: begin
          // done_q is raised while still in FLUSH so a start coinciding with
          // the done pulse is ignored; IDLE follows one cycle later.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_d == 3'd0) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output FIFO: head entry is the registered output
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_v_q    <= 1'b0;
      tail_v_q    <= 1'b0;
      head_data_q <= '0;
      head_addr_q <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (tail_v_q) begin
            head_data_q <= tail_data_q;
            head_addr_q <= tail_addr_q;
          end else begin
            head_data_q <= rq_row;
            head_addr_q <= inflight_addr_q;
          end
        end
        2'b10: begin
          if (!head_v_q) begin
            head_v_q    <= 1'b1;
            head_data_q <= rq_row;
            head_addr_q <= inflight_addr_q;
          end else begin
            tail_v_q <= 1'b1;
          end
        end
        2'b01: begin
          head_v_q <= tail_v_q;
          tail_v_q <= 1'b0;
          if (tail_v_q) begin
            head_data_q <= tail_data_q;
            head_addr_q <= tail_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && head_v_q && (!pop || tail_v_q)) begin
      tail_data_q <= rq_row;
      tail_addr_q <= inflight_addr_q;
    end
  end

  assign read_accumulator_o    = rd_en;
  assign accumulator_addr_rd_o = addr_q;
  assign out_if.out_valid      = head_v_q;
  assign out_if.out_data       = head_data_q;
  assign out_if.out_addr       = head_addr_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;

endmodule

// File: tb/tb_accumulator_drain_unit.sv
// ---------------------------------------------------------------------------
// tb_accumulator_drain_unit
// Randomised and directed drains against a floor-division reference model.
// Expected rows are queued when a drain starts; a negedge monitor pops and
// compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_accumulator_drain_unit;
  localparam int MS  = 32;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int ADW = 10;
  localparam int DW  = MS * OW;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start = 1'b0;
  logic [ADW:0]      nrows = '0;
  logic [4:0]        sh = '0;
  logic              relu = 1'b0;
  logic              rd;
  logic [ADW-1:0]    rd_addr;
  logic [MS*AW-1:0]  acc_data = '0;
  logic              rdy = 1'b1;
  logic              busy;
  logic              done;

  accumulator_drain_unit_if #(.MUL_SIZE(MS), .OUT_WIDTH(OW), .ADDR_WIDTH(ADW)) out_if ();
  assign out_if.out_ready = rdy;

  accumulator_drain_unit #(
    .MUL_SIZE(MS), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .start_i               (start),
    .num_rows_i            (nrows),
    .shift_i               (sh),
    .relu_en_i             (relu),
    .read_accumulator_o    (rd),
    .accumulator_addr_rd_o (rd_addr),
    .accumulator_data_i    (acc_data),
    .out_if                (out_if),
    .busy_o                (busy),
    .done_o                (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } exp_t;

  logic [MS*AW-1:0] mem [0:1023];
  exp_t             sb [$];
  exp_t             e;
  int               checks = 0;
  int               failures = 0;
  int               rd_drain = 0;
  int               hs_drain = 0;
  int               rdy_mode = 0;
  logic [DW-1:0]    last_out = '0;
  bit               prev_stall = 0;
  logic [DW-1:0]    prev_data;
  logic [ADW-1:0]   prev_addr;
  bit               got;
  logic [ADW-1:0]   ga;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: floor(acc / 2^s) with optional half-up bias, then ReLU, clamp.
  function automatic logic [7:0] ref_lane(input logic signed [31:0] acc, input int s, input bit r);
    longint a, d, q;
    a = acc;
    d = longint'(1) << s;
`ifdef ACCUM_DRAIN_ROUND_EN
    if (s > 0) a = a + d / 2;
`endif
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    if (r && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic logic [DW-1:0] ref_row(input logic [MS*AW-1:0] row, input int s, input bit r);
    logic [DW-1:0] res;
    res = '0;
    for (int k = 0; k < MS; k++) res[k*8 +: 8] = ref_lane(row[k*32 +: 32], s, r);
    return res;
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 1200)) - 32'd600;
      1:       return $urandom;
      2:       return 32'($urandom_range(0, 70000)) - 32'd35000;
      default: return {24'h0, 8'($urandom)};
    endcase
  endfunction

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < MS; k++) mem[i][k*32 +: 32] = rand_lane();
  endtask

  // Accumulator memory: data for a strobe seen in cycle c is presented in c+1.
  always begin
    @(negedge clk);
    got = rst_i && rd;
    ga  = rd_addr;
    @(posedge clk);
    #1;
    if (got) acc_data = mem[ga];
  end

  // Consumer ready pattern
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_i) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", DW'(out_if.out_valid), DW'(1));
        chk("stall_data", out_if.out_data, prev_data);
        chk("stall_addr", DW'(out_if.out_addr), DW'(prev_addr));
      end
      if (rd) begin
        chk("rd_addr", DW'(rd_addr), DW'(rd_drain));
        rd_drain++;
      end
      if (out_if.out_valid && rdy) begin
        hs_drain++;
        last_out = out_if.out_data;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row got addr=%0d want no row", out_if.out_addr);
        end else begin
          e = sb.pop_front();
          chk("row_addr", DW'(out_if.out_addr), DW'(e.addr));
          chk("row_data", out_if.out_data, e.data);
        end
      end
      if (rd) chk("outstanding_le2", DW'((rd_drain - hs_drain) <= 2), DW'(1));
      prev_stall = out_if.out_valid && !rdy;
      prev_data  = out_if.out_data;
      prev_addr  = out_if.out_addr;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"}, DW'(rd), '0);
    chk({tag, "_rd_addr"}, DW'(rd_addr), '0);
    chk({tag, "_valid"}, DW'(out_if.out_valid), '0);
    chk({tag, "_data"}, out_if.out_data, '0);
    chk({tag, "_addr"}, DW'(out_if.out_addr), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
  endtask

  task automatic run_drain(input int n, input int s, input bit r, input int mode,
                           input bit inj, input bit at_done);
    int cyc;
    int done_cyc;
    rdy_mode = mode;
    rd_drain = 0;
    hs_drain = 0;
    nrows    = (ADW+1)'(n);
    sh       = 5'(s);
    relu     = r;
    for (int i = 0; i < n; i++) sb.push_back(exp_t'{addr: i, data: ref_row(mem[i], s, r)});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    while (done_cyc < 0 && cyc <= 4*n + 40) begin
      @(negedge clk);
      if (cyc == 1) chk("busy_cycle1", DW'(busy), DW'(1));
      if (done) begin
        done_cyc = cyc;
        chk("busy_low_at_done", DW'(busy), '0);
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        start = inj && (cyc == 4);
      end
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=no_done want=done n=%0d", n);
    end else begin
      if (mode == 0) chk("done_cycle", DW'(done_cyc), DW'((n == 0) ? 2 : n + 3));
      if (at_done) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("no_restart_busy", DW'(busy), '0);
      chk("done_one_cycle", DW'(done), '0);
    end
    chk("hs_count", DW'(hs_drain), DW'(n));
    chk("rd_count", DW'(rd_drain), DW'(n));
    chk("sb_empty", DW'(sb.size()), '0);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int pat [4];
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All lanes 0x100, shift 2 -> 0x40
    for (int k = 0; k < MS; k++) mem[0][k*32 +: 32] = 32'h100;
    run_drain(1, 2, 0, 0, 0, 0);
    chk("lanes_0x40", last_out, {MS{8'h40}});

    // Saturation and ReLU
    pat[0] = -300; pat[1] = 300; pat[2] = -5; pat[3] = 127;
    for (int k = 0; k < MS; k++) mem[0][k*32 +: 32] = 32'(pat[k % 4]);
    run_drain(1, 0, 0, 0, 0, 0);
    chk("sat_lanes", DW'(last_out[31:0]), DW'({8'h7f, 8'hfb, 8'h7f, 8'h80}));
    run_drain(1, 0, 1, 0, 0, 0);
    chk("relu_lanes", DW'(last_out[31:0]), DW'({8'h7f, 8'h00, 8'h7f, 8'h00}));

    // Rounding boundary
    mem[0] = '0;
    mem[0][31:0]  = 32'd6;
    mem[0][63:32] = -32'sd6;
    run_drain(1, 2, 0, 0, 0, 0);
`ifdef ACCUM_DRAIN_ROUND_EN
    chk("round_lanes", DW'(last_out[15:0]), DW'({8'hff, 8'h02}));
`else
    chk("trunc_lanes", DW'(last_out[15:0]), DW'({8'hfe, 8'h01}));
`endif

    // Zero rows
    run_drain(0, 3, 0, 0, 0, 1);

    // Start during busy drain and start coinciding with done
    fill(8);
    run_drain(8, 4, 0, 0, 1, 1);

    // 64 rows with alternating ready
    fill(64);
    run_drain(64, 7, 1, 1, 0, 0);

    // Reset mid-drain
    fill(16);
    rdy_mode = 0;
    rd_drain = 0;
    hs_drain = 0;
    for (int i = 0; i < 16; i++) sb.push_back(exp_t'{addr: i, data: ref_row(mem[i], 1, 0)});
    nrows = 17'(16);
    sh = 5'd1;
    relu = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (hs_drain < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      failures++;
      $display("FAIL reset_wait got=%0d want=5 handshakes", hs_drain);
    end
    #2 rst_i = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    fill(4);
    run_drain(4, 5, 0, 0, 0, 0);

    // Randomised drains
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 40);
      fill(n);
      run_drain(n, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                (t % 2 == 0) ? 2 : 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
